// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type, stop-check constants and sampling-edge rules for the UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // stp_err polarity from the stop-check stage, and the idle/stop line level
  localparam logic NO_ERROR = 1'b1;
  localparam logic ERROR    = 1'b0;
  localparam logic STOP_BIT = 1'b1;

  // H: middle of the bit; the vote lands at H+1, so decisions are taken at H+2
  function automatic int half_edge(input int prescale);
    return prescale / 2;
  endfunction

  function automatic int decision_edge(input int prescale);
    return prescale / 2 + 2;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversampling edge counter and data-bit counter driven by the receive FSM
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE = 8,
  parameter int DATA_W   = 8,
  localparam int EW = $clog2(PRESCALE),
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_bit_clr,
  input  logic          i_bit_inc,
  output logic [EW-1:0] o_edge_cnt,
  output logic [BW-1:0] o_bit_cnt,
  output logic          o_edge_last
);

  logic [EW-1:0] r_edge_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          w_edge_last;

  assign w_edge_last = (r_edge_cnt == EW'(PRESCALE - 1));

  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_edge_cnt <= '0;
    end else if (i_en) begin
      r_edge_cnt <= w_edge_last ? '0 : r_edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || i_bit_clr) begin
      r_bit_cnt <= '0;
    end else if (i_bit_inc) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign o_edge_cnt  = r_edge_cnt;
  assign o_bit_cnt   = r_bit_cnt;
  assign o_edge_last = w_edge_last;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive front end: synchroniser, 3-sample vote, frame sequencer and result pulses
module uart_rx_ctrl #(
  parameter int PRESCALE = 8,
  parameter int DATA_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              stp_err,
  output logic              stp_chk_en,
  output logic              sampled_bit,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy
);

  import uart_rx_pkg::*;

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int H  = half_edge(PRESCALE);
  localparam int D  = decision_edge(PRESCALE);

  localparam logic [EW-1:0] E_S0   = EW'(H - 1);
  localparam logic [EW-1:0] E_S1   = EW'(H);
  localparam logic [EW-1:0] E_VOTE = EW'(H + 1);
  localparam logic [EW-1:0] E_DEC  = EW'(D);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  rx_state_e r_state;
  rx_state_e w_next_state;

  logic              r_sync1;
  logic              r_rx_s;
  logic              r_s0;
  logic              r_s1;
  logic              r_sampled;
  logic              r_par_en;
  logic              r_par_typ;
  logic              r_par_bad;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_p_data;
  logic              r_data_valid;
  logic              r_par_err;
  logic              r_frm_err;

  logic [EW-1:0]     w_edge_cnt;
  logic [BW-1:0]     w_bit_cnt;
  logic              w_edge_last;
  logic              w_at_dec;
  logic              w_vote;
  logic              w_par_exp;

  logic              w_cnt_en;
  logic              w_cnt_clr;
  logic              w_bit_clr;
  logic              w_bit_inc;
  logic              w_latch_cfg;
  logic              w_par_clr;
  logic              w_par_chk;
  logic              w_shift_en;
  logic              w_stop_dec;

  uart_rx_edge_bit_cnt #(
    .PRESCALE (PRESCALE),
    .DATA_W   (DATA_W)
  ) u_cnt (
    .CLK         (CLK),
    .RST         (RST),
    .i_en        (w_cnt_en),
    .i_clr       (w_cnt_clr),
    .i_bit_clr   (w_bit_clr),
    .i_bit_inc   (w_bit_inc),
    .o_edge_cnt  (w_edge_cnt),
    .o_bit_cnt   (w_bit_cnt),
    .o_edge_last (w_edge_last)
  );

  // Flops reset to the idle line level so reset never looks like a start bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= STOP_BIT;
      r_rx_s  <= STOP_BIT;
    end else begin
      r_sync1 <= RX_IN;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_at_dec  = (w_edge_cnt == E_DEC);
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_par_exp = (^r_shift) ^ r_par_typ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s0      <= STOP_BIT;
      r_s1      <= STOP_BIT;
      r_sampled <= STOP_BIT;
    end else if (r_state != IDLE) begin
      if (w_edge_cnt == E_S0) r_s0 <= r_rx_s;
      if (w_edge_cnt == E_S1) r_s1 <= r_rx_s;
      if (w_edge_cnt == E_VOTE) r_sampled <= w_vote;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_en     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_latch_cfg  = 1'b0;
    w_par_clr    = 1'b0;
    w_par_chk    = 1'b0;
    w_shift_en   = 1'b0;
    w_stop_dec   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // The detection cycle itself is edge 0 of the start bit
        if (r_rx_s == 1'b0) begin
          w_next_state = START;
          w_cnt_en     = 1'b1;
          w_latch_cfg  = 1'b1;
          w_par_clr    = 1'b1;
        end
      end
      START: begin
        w_cnt_en = 1'b1;
        if (w_at_dec && r_sampled) begin
          w_next_state = IDLE;
          w_cnt_clr    = 1'b1;
        end else if (w_edge_last) begin
          w_next_state = DATA;
          w_bit_clr    = 1'b1;
        end
      end
      DATA: begin
        w_cnt_en   = 1'b1;
        w_shift_en = w_at_dec;
        if (w_edge_last) begin
          if (w_bit_cnt == B_LAST) w_next_state = r_par_en ? PARITY : STOP;
          else                     w_bit_inc    = 1'b1;
        end
      end
      PARITY: begin
        w_cnt_en  = 1'b1;
        w_par_chk = w_at_dec;
        if (w_edge_last) w_next_state = STOP;
      end
      STOP: begin
        w_cnt_en = 1'b1;
        // Leave at the decision edge so a back-to-back start bit is not missed
        if (w_at_dec) begin
          w_stop_dec   = 1'b1;
          w_next_state = IDLE;
          w_cnt_clr    = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_frm_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_frm_err    <= 1'b0;
      if (w_latch_cfg) begin
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
      end
      if (w_par_clr)      r_par_bad <= 1'b0;
      else if (w_par_chk) r_par_bad <= (r_sampled != w_par_exp);
      if (w_shift_en) begin
        r_shift <= (r_shift >> 1) | (DATA_W'(r_sampled) << (DATA_W - 1));
      end
      if (w_stop_dec) begin
        if (r_par_bad) begin
          r_par_err <= 1'b1;
        end else if (stp_err != NO_ERROR) begin
          r_frm_err <= 1'b1;
        end else begin
          r_data_valid <= 1'b1;
          r_p_data     <= r_shift;
        end
      end
    end
  end

  assign stp_chk_en  = w_stop_dec;
  assign sampled_bit = r_sampled;
  assign P_DATA      = r_p_data;
  assign data_valid  = r_data_valid;
  assign par_err     = r_par_err;
  assign frm_err     = r_frm_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized self-checking bench for uart_rx_ctrl against a frame-level outcome model
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int P    = 8;
  localparam int DW   = 8;
  localparam int DEC  = P / 2 + 2;
  localparam int K_DV = 1;
  localparam int K_PE = 2;
  localparam int K_FE = 3;

  logic          CLK     = 1'b0;
  logic          RST     = 1'b1;
  logic          RX_IN   = 1'b1;
  logic          PAR_EN  = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          stp_err;
  logic          stp_chk_en;
  logic          sampled_bit;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          frm_err;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int stp_cnt  = 0;
  int busy_cnt = 0;
  int rd_ptr   = 0;
  int stp_rd   = 0;
  int          ev_kind[$];
  int          ev_cyc[$];
  logic [DW-1:0] ev_data[$];
  logic [DW-1:0] exp_pdata = '0;

  uart_rx_ctrl #(.PRESCALE(P), .DATA_W(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .stp_err     (stp_err),
    .stp_chk_en  (stp_chk_en),
    .sampled_bit (sampled_bit),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .frm_err     (frm_err),
    .busy        (busy)
  );

  // Stop-check stage: stop bit must equal the idle level
  assign stp_err = stp_chk_en ? ((sampled_bit == STOP_BIT) ? NO_ERROR : ERROR) : NO_ERROR;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (stp_chk_en) stp_cnt <= stp_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (data_valid) begin ev_kind.push_back(K_DV); ev_cyc.push_back(cyc); ev_data.push_back(P_DATA); end
    if (par_err)    begin ev_kind.push_back(K_PE); ev_cyc.push_back(cyc); ev_data.push_back(P_DATA); end
    if (frm_err)    begin ev_kind.push_back(K_FE); ev_cyc.push_back(cyc); ev_data.push_back(P_DATA); end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic hold(input logic v, input int n);
    RX_IN = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic par_ok, input logic stop_b, input int glitch_bit,
                            output int t_fall);
    logic par_v;
    PAR_EN  = pe;
    PAR_TYP = pt;
    t_fall  = cyc;
    hold(1'b0, P);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    for (int i = 0; i < DW; i++) begin
      if (i == glitch_bit) begin
        hold(d[i], P / 2);
        hold(~d[i], 1);
        hold(d[i], P - P / 2 - 1);
      end else begin
        hold(d[i], P);
      end
    end
    par_v = (^d) ^ pt ^ ~par_ok;
    if (pe) hold(par_v, P);
    hold(stop_b, P);
    RX_IN = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [DW-1:0] d, input logic pe,
                              input logic par_ok, input logic stop_b, input int t_fall);
    int kind;
    int lat;
    lat = 2 + (1 + DW + (pe ? 1 : 0)) * P + DEC + 1;
    if (pe && !par_ok)          kind = K_PE;
    else if (stop_b != STOP_BIT) kind = K_FE;
    else begin
      kind      = K_DV;
      exp_pdata = d;
    end
    check_eq({tag, "_nev"}, ev_kind.size() - rd_ptr, 1);
    if (ev_kind.size() > rd_ptr) begin
      check_eq({tag, "_kind"}, ev_kind[rd_ptr], kind);
      check_eq({tag, "_cyc"}, ev_cyc[rd_ptr] - t_fall, lat);
      check_eq({tag, "_pdata"}, 32'(ev_data[rd_ptr]), 32'(exp_pdata));
    end
    rd_ptr = ev_kind.size();
    check_eq({tag, "_stpchk"}, stp_cnt - stp_rd, 1);
    stp_rd = stp_cnt;
  endtask

  task automatic expect_quiet(input string tag);
    check_eq({tag, "_nev"}, ev_kind.size() - rd_ptr, 0);
    check_eq({tag, "_stpchk"}, stp_cnt - stp_rd, 0);
    rd_ptr = ev_kind.size();
    stp_rd = stp_cnt;
  endtask

  initial begin
    int t0;
    int t1;
    int b0;
    int period;
    logic [DW-1:0] d;
    logic pe, pt, pok, sb;

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_dv", 32'(data_valid), 0);
    check_eq("rst_perr", 32'(par_err), 0);
    check_eq("rst_ferr", 32'(frm_err), 0);
    check_eq("rst_stpchk", 32'(stp_chk_en), 0);
    check_eq("rst_pdata", 32'(P_DATA), 0);
    check_eq("rst_sbit", 32'(sampled_bit), 1);
    RST = 1'b0;

    b0 = busy_cnt;
    hold(1'b1, 200);
    expect_quiet("idle");
    check_eq("idle_busy", busy_cnt - b0, 0);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, -1, t0);
    hold(1'b1, 20);
    expect_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b1, t0);
    check_eq("a5_pdata_now", 32'(P_DATA), 32'hA5);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, t0);
    hold(1'b1, 20);
    expect_frame("3c_bad", 8'h3C, 1'b1, 1'b0, 1'b1, t0);
    check_eq("3c_bad_hold", 32'(P_DATA), 32'hA5);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, t0);
    hold(1'b1, 20);
    expect_frame("3c_ok", 8'h3C, 1'b1, 1'b1, 1'b1, t0);

    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    hold(1'b1, 30);
    expect_frame("55_stop", 8'h55, 1'b0, 1'b1, 1'b0, t0);

    hold(1'b0, 2);
    hold(1'b1, 30);
    expect_quiet("glitch2");
    check_eq("glitch2_busy", 32'(busy), 0);

    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 3, t0);
    hold(1'b1, 20);
    expect_frame("f0_glitch", 8'hF0, 1'b0, 1'b1, 1'b1, t0);

    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b1, -1, t0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, -1, t1);
    hold(1'b1, 20);
    check_eq("b2b_nev", ev_kind.size() - rd_ptr, 2);
    if (ev_kind.size() - rd_ptr >= 2) begin
      check_eq("b2b_k0", ev_kind[rd_ptr], K_DV);
      check_eq("b2b_d0", 32'(ev_data[rd_ptr]), 32'h01);
      check_eq("b2b_c0", ev_cyc[rd_ptr] - t0, 2 + (1 + DW) * P + DEC + 1);
      check_eq("b2b_k1", ev_kind[rd_ptr + 1], K_DV);
      check_eq("b2b_d1", 32'(ev_data[rd_ptr + 1]), 32'hFE);
      check_eq("b2b_gap", ev_cyc[rd_ptr + 1] - ev_cyc[rd_ptr], (DW + 2) * P);
    end
    exp_pdata = 8'hFE;
    rd_ptr = ev_kind.size();
    check_eq("b2b_stpchk", stp_cnt - stp_rd, 2);
    stp_rd = stp_cnt;

    // Break: two frames restart back to back, third start sees the line return high
    PAR_EN = 1'b0;
    period = (1 + DW) * P + DEC + 1;
    t0 = cyc;
    hold(1'b0, 2 * period + 1);
    hold(1'b1, 30);
    check_eq("brk_nev", ev_kind.size() - rd_ptr, 2);
    if (ev_kind.size() - rd_ptr >= 2) begin
      check_eq("brk_k0", ev_kind[rd_ptr], K_FE);
      check_eq("brk_c0", ev_cyc[rd_ptr] - t0, 2 + period);
      check_eq("brk_k1", ev_kind[rd_ptr + 1], K_FE);
      check_eq("brk_c1", ev_cyc[rd_ptr + 1] - t0, 2 + 2 * period);
    end
    rd_ptr = ev_kind.size();
    check_eq("brk_stpchk", stp_cnt - stp_rd, 2);
    stp_rd = stp_cnt;
    check_eq("brk_pdata", 32'(P_DATA), 32'(exp_pdata));

    for (int n = 0; n < 16; n++) begin
      d   = DW'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      pok = ($urandom_range(0, 3) != 0);
      sb  = ($urandom_range(0, 3) != 0);
      send_frame(d, pe, pt, pok, sb, -1, t0);
      hold(1'b1, $urandom_range(12, 40));
      expect_frame($sformatf("rnd%0d", n), d, pe, pok, sb, t0);
    end

    PAR_EN = 1'b0;
    hold(1'b0, P);
    hold(1'b1, 3 * P);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_pdata", 32'(P_DATA), 0);
    RST = 1'b0;
    hold(1'b1, 100);
    expect_quiet("mid_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Front end and sequencer of the UART receiver.
- Synchronises RX_IN and oversamples it, with a 3-sample majority vote per bit.
- Frames start, data, optional parity and stop bits, and deserialises the data LSB-first.
- Drives the downstream stop-check stage (stp_chk_en, sampled_bit) and consumes its stp_err verdict.
- Presents the received byte with a one-cycle data_valid pulse, or an error pulse.

Parameters:
- PRESCALE, 8: CLK cycles per UART bit. Must be even and ≥ 6.
- DATA_W, 8: data bits per frame.

Ports:
- CLK, in, 1: sole clock.
- RST, in, 1: synchronous, active-high reset.
- RX_IN, in, 1: asynchronous serial line; idle level 1.
- PAR_EN, in, 1: parity bit present. Latched at start detection.
- PAR_TYP, in, 1: 0 = even parity, 1 = odd parity. Latched at start detection.
- stp_err, in, 1: verdict from the stop-check stage. 1 = stop bit correct (NO_ERROR), 0 = error. Combinational response to stp_chk_en/sampled_bit.
- stp_chk_en, out, 1: enables the stop-check stage for one cycle.
- sampled_bit, out, 1: registered majority-voted bit value.
- P_DATA, out, DATA_W: last good byte. Bit 0 is the first received bit.
- data_valid, out, 1: one-cycle pulse when P_DATA is updated.
- par_err, out, 1: one-cycle pulse; frame dropped because of a parity mismatch.
- frm_err, out, 1: one-cycle pulse; frame dropped because of a bad stop bit.
- busy, out, 1: high in any state except IDLE.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State goes to IDLE; counters go to 0.
  - Synchroniser flops go to 1; sampled_bit = 1.
  - P_DATA = 0; data_valid, par_err, frm_err, stp_chk_en, busy = 0.
  - Reset mid-frame discards the frame with no pulse.
- Synchroniser: two flops; rx_s is RX_IN delayed by 2 cycles.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 and wraps.
  - bit_cnt runs 0..DATA_W-1.
  - Let H = PRESCALE/2 and D = H+2 (the decision edge).
- Sampling, in every non-IDLE state:
  - s0 is registered at edge H-1, s1 at edge H.
  - At edge H+1, sampled_bit <= majority(s0, s1, rx_s).
  - sampled_bit holds its value otherwise.
- IDLE:
  - When rx_s = 0, go to START. The detection cycle counts as edge 0 (START is entered with edge_cnt = 1).
  - Latch PAR_EN and PAR_TYP in the same cycle.
- START:
  - At edge D, if sampled_bit = 1 (glitch), go to IDLE silently with no pulse.
  - Otherwise, at edge PRESCALE-1, go to DATA with bit_cnt = 0.
- DATA:
  - At edge D, shift sampled_bit into the shift register at the MSB (shift right).
  - At edge PRESCALE-1: if bit_cnt = DATA_W-1, go to PARITY if the latched PAR_EN = 1, else to STOP. Otherwise increment bit_cnt.
- PARITY:
  - At edge D, set par_bad = (sampled_bit ≠ expected).
  - expected = XOR of the shift register for even parity; its inverse for odd parity.
  - At edge PRESCALE-1, go to STOP.
  - par_bad clears on entry to START.
- STOP:
  - stp_chk_en = 1 exactly in the edge-D cycle (decoded from registers, glitch-free).
  - In that cycle, read stp_err.
  - Next cycle, pulse exactly one of the following, by priority:
    - par_bad → par_err;
    - else stp_err = 0 → frm_err;
    - else data_valid, with P_DATA <= shift register in that same cycle.
  - Go to IDLE on the cycle after edge D without waiting for the end of the stop bit, so back-to-back frames are accepted.
  - P_DATA holds its value when a frame is dropped.
- Continuous low (break) on RX_IN: each frame ends with frm_err, then reception restarts immediately.
- PAR_EN/PAR_TYP changes mid-frame have no effect.
- Latency: with PRESCALE=8 and no parity, data_valid is high exactly 81 cycles after the RX_IN falling edge (2 synchroniser + 72 + 6 + 1). Parity adds 8 cycles.

Decomposition:
- uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the constants NO_ERROR = 1, ERROR = 0, STOP_BIT = 1;
  - the localparam rule for H and D.
- One sub-module, uart_rx_edge_bit_cnt:
  - holds edge_cnt and bit_cnt;
  - enable, clear and bit_inc controls come from the FSM;
  - outputs edge_last, which is high at edge PRESCALE-1.

Test Plan:
- Idle line held at 1 for 200 cycles → busy = 0, and no pulse on data_valid, par_err, frm_err or stp_chk_en.
- Frame 0xA5, PAR_EN = 0, good stop bit, stage model returns stp_err = 1 → data_valid high for one cycle at +81, P_DATA = 0xA5, stp_chk_en high for exactly one cycle.
- Frame 0x3C, PAR_EN = 1, PAR_TYP = 0, parity bit 1 (wrong) → par_err at +89, data_valid = 0, P_DATA unchanged; then frame 0x3C with parity bit 0 → data_valid, P_DATA = 0x3C.
- Frame 0x55 with stop bit 0 (stp_err = 0) → frm_err pulse, no data_valid.
- 2-cycle low glitch on RX_IN → FSM returns to IDLE, no pulses. A 1-cycle glitch inside bit 3 of 0xF0 is voted out → P_DATA = 0xF0.
- Two back-to-back frames, 0x01 then 0xFE, with no idle gap → two data_valid pulses 80 cycles apart; RST asserted mid-frame → busy = 0 next cycle and no pulse.
